// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the 12-bit CPU control path.
//   - Default widths for the program counter, instruction word and datapath.
//   - Bit positions of every instruction field.
//   - opcode_t, alu_op_t and state_t enumerations.
//   - op_is_legal(): true for opcodes the control unit can execute.
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DEF_PC_W    = 3;
   localparam int DEF_INSTR_W = 12;
   localparam int DEF_DATA_W  = 4;

   // Opcode field
   localparam int OP_HI      = 11;
   localparam int OP_LO      = 9;
   // LOAD destination / STORE source register and memory address
   localparam int LS_REG_HI  = 6;
   localparam int LS_REG_LO  = 4;
   localparam int LS_ADDR_HI = 3;
   localparam int LS_ADDR_LO = 0;
   // ALU format: destination, second source (ADDI source), first source (ADDI immediate)
   localparam int AL_RD_HI   = 8;
   localparam int AL_RD_LO   = 6;
   localparam int AL_RB_HI   = 5;
   localparam int AL_RB_LO   = 3;
   localparam int AL_RA_HI   = 2;
   localparam int AL_RA_LO   = 0;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'b000,
      OP_STORE = 3'b001,
      OP_SUB   = 3'b010,
      OP_ADD   = 3'b011,
      OP_ILL4  = 3'b100,
      OP_ADDI  = 3'b101,
      OP_ILL6  = 3'b110,
      OP_JUMP  = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      ALU_PASS_A    = 2'b00,
      ALU_ADD_A_B   = 2'b01,
      ALU_SUB_A_B   = 2'b10,
      ALU_ADD_A_IMM = 2'b11
   } alu_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_HALT
   } state_t;

   function automatic logic op_is_legal(input opcode_t op);
      return (op != OP_ILL4) && (op != OP_ILL6);
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// ----------------------------------------------------------------------------
// instr_decoder
// Purely combinational: splits an instruction word into control fields.
// Fields an opcode does not use are driven to 0, so an all-zero word
// decodes to all-zero fields.
// Ports:
//   i_ir           in  INSTR_W  instruction word to decode
//   o_is_load      out 1        LOAD
//   o_is_store     out 1        STORE
//   o_is_alu       out 1        SUB / ADD / ADDI (register write-back)
//   o_is_jump      out 1        JUMP
//   o_is_illegal   out 1        unsupported opcode
//   o_rf_waddr     out 3        register-file write address
//   o_rf_raddr_a   out 3        register-file read port A address
//   o_rf_raddr_b   out 3        register-file read port B address
//   o_alu_op       out 2        ALU operation
//   o_imm          out DATA_W   zero-extended immediate
//   o_dmem_addr    out 4        data memory address
//   o_jump_target  out PC_W     jump destination
// ----------------------------------------------------------------------------
module instr_decoder
   import cpu_pkg::*;
#(
   parameter int PC_W    = DEF_PC_W,
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic [INSTR_W-1:0] i_ir,
   output logic               o_is_load,
   output logic               o_is_store,
   output logic               o_is_alu,
   output logic               o_is_jump,
   output logic               o_is_illegal,
   output logic [2:0]         o_rf_waddr,
   output logic [2:0]         o_rf_raddr_a,
   output logic [2:0]         o_rf_raddr_b,
   output alu_op_t            o_alu_op,
   output logic [DATA_W-1:0]  o_imm,
   output logic [3:0]         o_dmem_addr,
   output logic [PC_W-1:0]    o_jump_target
);

   opcode_t w_op;
   assign w_op = opcode_t'(i_ir[OP_HI:OP_LO]);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      o_is_load     = 1'b0;
      o_is_store    = 1'b0;
      o_is_alu      = 1'b0;
      o_is_jump     = 1'b0;
      o_is_illegal  = !op_is_legal(w_op);
      o_rf_waddr    = '0;
      o_rf_raddr_a  = '0;
      o_rf_raddr_b  = '0;
      o_alu_op      = ALU_PASS_A;
      o_imm         = '0;
      o_dmem_addr   = '0;
      o_jump_target = '0;
      case (w_op)
         OP_LOAD: begin
            o_is_load   = 1'b1;
            o_rf_waddr  = i_ir[LS_REG_HI:LS_REG_LO];
            o_dmem_addr = i_ir[LS_ADDR_HI:LS_ADDR_LO];
         end
         OP_STORE: begin
            // Store data comes from RF port A.
            o_is_store   = 1'b1;
            o_rf_raddr_a = i_ir[LS_REG_HI:LS_REG_LO];
            o_dmem_addr  = i_ir[LS_ADDR_HI:LS_ADDR_LO];
         end
         OP_SUB, OP_ADD: begin
            o_is_alu     = 1'b1;
            o_rf_waddr   = i_ir[AL_RD_HI:AL_RD_LO];
            o_rf_raddr_a = i_ir[AL_RA_HI:AL_RA_LO];
            o_rf_raddr_b = i_ir[AL_RB_HI:AL_RB_LO];
            o_alu_op     = (w_op == OP_SUB) ? ALU_SUB_A_B : ALU_ADD_A_B;
         end
         OP_ADDI: begin
            // The single source register is presented on both read ports so
            // the ALU finds it whichever operand it adds the immediate to.
            o_is_alu     = 1'b1;
            o_rf_waddr   = i_ir[AL_RD_HI:AL_RD_LO];
            o_rf_raddr_a = i_ir[AL_RB_HI:AL_RB_LO];
            o_rf_raddr_b = i_ir[AL_RB_HI:AL_RB_LO];
            o_imm        = DATA_W'(i_ir[AL_RA_HI:AL_RA_LO]);
            o_alu_op     = ALU_ADD_A_IMM;
         end
         OP_JUMP: begin
            o_is_jump     = 1'b1;
            o_jump_target = i_ir[PC_W-1:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
// Multi-cycle fetch/decode/execute sequencer for the 12-bit CPU. Owns the
// program counter and instruction register and issues one-cycle strobes to
// the register file, ALU and data memory.
// Configuration macro: ILLEGAL_HALT_EN -- when defined, an illegal opcode
// stops the machine in HALT (left only by reset); otherwise it runs as a NOP.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   run              1 = keep executing, 0 = stop at next instruction boundary
//   instruction      instruction-memory read data (valid the cycle after pc)
//   pc               fetch address
//   rf_we, rf_waddr, rf_raddr_a, rf_raddr_b   register-file control
//   wb_sel           write-back source: 0 = ALU, 1 = data memory
//   alu_op, imm      ALU operation and zero-extended immediate
//   dmem_addr, dmem_re, dmem_we               data-memory control
//   busy             1 outside IDLE/HALT
//   illegal          sticky illegal-opcode flag
// ----------------------------------------------------------------------------
module control_unit
   import cpu_pkg::*;
#(
   parameter int PC_W    = DEF_PC_W,
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic [INSTR_W-1:0] instruction,
   output logic [PC_W-1:0]    pc,
   output logic               rf_we,
   output logic [2:0]         rf_waddr,
   output logic [2:0]         rf_raddr_a,
   output logic [2:0]         rf_raddr_b,
   output logic               wb_sel,
   output logic [1:0]         alu_op,
   output logic [DATA_W-1:0]  imm,
   output logic [3:0]         dmem_addr,
   output logic               dmem_re,
   output logic               dmem_we,
   output logic               busy,
   output logic               illegal
);

   state_t             r_state;
   logic [PC_W-1:0]    r_pc;
   logic [INSTR_W-1:0] r_ir;
   logic               r_rf_we;
   logic               r_wb_sel;
   logic               r_dmem_re;
   logic               r_dmem_we;
   logic               r_busy;
   logic               r_illegal;

   logic [INSTR_W-1:0] w_ir_dec;
   logic               w_is_load;
   logic               w_is_store;
   logic               w_is_alu;
   logic               w_is_jump;
   logic               w_is_illegal;
   alu_op_t            w_alu_op;
   logic [PC_W-1:0]    w_jump_target;

   // During DECODE the decoder looks at the word arriving from memory so the
   // EXEC strobes can be registered on the same edge that loads the IR.
   // No strobe is active in DECODE, so the early field values are harmless.
   assign w_ir_dec = (r_state == ST_DECODE) ? instruction : r_ir;

   instr_decoder #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W),
      .DATA_W  (DATA_W)
   ) u_decoder (
      .i_ir          (w_ir_dec),
      .o_is_load     (w_is_load),
      .o_is_store    (w_is_store),
      .o_is_alu      (w_is_alu),
      .o_is_jump     (w_is_jump),
      .o_is_illegal  (w_is_illegal),
      .o_rf_waddr    (rf_waddr),
      .o_rf_raddr_a  (rf_raddr_a),
      .o_rf_raddr_b  (rf_raddr_b),
      .o_alu_op      (w_alu_op),
      .o_imm         (imm),
      .o_dmem_addr   (dmem_addr),
      .o_jump_target (w_jump_target)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_pc      <= '0;
         r_ir      <= '0;
         r_rf_we   <= 1'b0;
         r_wb_sel  <= 1'b0;
         r_dmem_re <= 1'b0;
         r_dmem_we <= 1'b0;
         r_busy    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees the
         // pre-edge register values. Strobes default low: each lasts one cycle.
         r_rf_we   <= 1'b0;
         r_wb_sel  <= 1'b0;
         r_dmem_re <= 1'b0;
         r_dmem_we <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (run) begin
                  r_state <= ST_FETCH;
                  r_busy  <= 1'b1;
               end
            end
            ST_FETCH: r_state <= ST_DECODE;
            ST_DECODE: begin
               r_ir      <= instruction;
               r_rf_we   <= w_is_alu;
               r_dmem_we <= w_is_store;
               r_dmem_re <= w_is_load;
               if (w_is_illegal) r_illegal <= 1'b1;
               r_state   <= ST_EXEC;
            end
            ST_EXEC, ST_MEM: begin
               if (r_state == ST_EXEC && w_is_load) begin
                  r_rf_we  <= 1'b1;
                  r_wb_sel <= 1'b1;
                  r_state  <= ST_MEM;
               end
`ifdef ILLEGAL_HALT_EN
               else if (w_is_illegal) begin
                  r_state <= ST_HALT;
                  r_busy  <= 1'b0;
               end
`endif
               else begin
                  // Final cycle: advance pc and sample run at the boundary.
                  r_pc    <= w_is_jump ? w_jump_target : r_pc + PC_W'(1);
                  r_state <= run ? ST_FETCH : ST_IDLE;
                  r_busy  <= run;
               end
            end
            ST_HALT: r_state <= ST_HALT;
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign pc      = r_pc;
   assign rf_we   = r_rf_we;
   assign wb_sel  = r_wb_sel;
   assign alu_op  = w_alu_op;
   assign dmem_re = r_dmem_re;
   assign dmem_we = r_dmem_we;
   assign busy    = r_busy;
   assign illegal = r_illegal;

endmodule
